// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered ID/EX decode stage with load-use, MUL issue-block and flush
module ctrl_decode_stage #(
  parameter int CTRL_W     = 10,
  parameter int REG_ADDR_W = 4,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic                  hazard,
  output logic                  mul_busy
);

  typedef enum logic {ST_RUN, ST_MUL_WAIT} state_t;

  localparam int             CNT_W      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam bit             MUL_WAITS  = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 1) : 0);
  localparam logic [3:0]     OP_MUL     = 4'b0010;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    r_out_valid;
  logic [CTRL_W-1:0]       r_ctrl;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [REG_ADDR_W-1:0]   r_rs1;
  logic [REG_ADDR_W-1:0]   r_rs2;

  logic [9:0]              w_dec;
  logic [CTRL_W-1:0]       w_dec_ctrl;
  logic                    w_adv;
  logic                    w_hazard;
  logic                    w_in_ready;
  logic                    w_accept;

  // Control rod: ALU ops carry the opcode low bits, memory/system ops put them in [6:4].
  always_comb begin
    w_dec = '0;
    if (!in_opcode[3]) begin
      w_dec[2:0] = in_opcode[2:0];
      w_dec[6]   = 1'b1;
      w_dec[9]   = 1'b1;
      w_dec[8]   = (in_opcode[1:0] != 2'b11);
    end else if (in_opcode[1:0] == 2'b11) begin
      w_dec[7]   = in_opcode[2];
      w_dec[3]   = !in_opcode[2];
    end else begin
      w_dec[6:4] = in_opcode[2:0];
      w_dec[9]   = in_opcode[1];
    end
  end

  assign w_dec_ctrl = CTRL_W'(w_dec);

  assign w_adv    = !r_out_valid || out_ready;
  assign w_hazard = r_out_valid && r_ctrl[4] && (r_rd != '0) && in_valid &&
                    ((w_dec[8] && (in_rs1 == r_rd)) || (w_dec[9] && (in_rs2 == r_rd)));
  assign w_in_ready = w_adv && (r_state == ST_RUN) && !w_hazard && !flush;
  assign w_accept   = in_valid && w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (MUL_WAITS && w_accept && (in_opcode == OP_MUL)) begin
            w_state_nxt = ST_MUL_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
        ST_MUL_WAIT: begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Bubbles load zeros so downstream never sees stale fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_accept;
      r_ctrl      <= w_accept ? w_dec_ctrl : '0;
      r_rd        <= w_accept ? in_rd  : '0;
      r_rs1       <= w_accept ? in_rs1 : '0;
      r_rs2       <= w_accept ? in_rs2 : '0;
    end
  end

  assign in_ready  = w_in_ready;
  assign hazard    = w_hazard;
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_ctrl;
  assign out_rd    = r_rd;
  assign out_rs1   = r_rs1;
  assign out_rs2   = r_rs2;
  assign mul_busy  = (r_state == ST_MUL_WAIT);

endmodule
